// File: rtl/uart_transmitter_if.sv
// Parallel-side handshake of the UART transmitter: byte request in, busy/done status out.
interface uart_transmitter_if;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_busy;
    logic       tx_done_tick;

    modport master (
        output tx_start,
        output din,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  din,
        output tx_busy,
        output tx_done_tick
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART serializer paced by a shared 16x-baud s_tick: start bit, DBIT data bits LSB first,
// optional parity bit, then SB_TICK ticks of stop; tx is registered and idles high.
module uart_transmitter #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_EN  = 0,
    parameter int PAR_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_tick,
    uart_transmitter_if.slave bus,
    output logic              tx
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] S_LAST    = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);

    state_t     state;
    logic [4:0] s;
    logic [2:0] n;
    logic [7:0] b;
    logic       p;
    logic       tx_reg;
    logic       tx_next;

    always_comb begin
        tx_next = 1'b1;
        case (state)
            START:   tx_next = 1'b0;
            DATA:    tx_next = b[0];
            PARITY:  tx_next = p;
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            b      <= '0;
            p      <= 1'b0;
            tx_reg <= 1'b1;
        end else begin
            tx_reg <= tx_next;
            case (state)
                IDLE: begin
                    // Acceptance does not wait for s_tick; the start bit counts from the next tick.
                    if (bus.tx_start) begin
                        b     <= bus.din;
                        s     <= '0;
                        p     <= (^bus.din[DBIT-1:0]) ^ (PAR_ODD != 0);
                        state <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            state <= DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s <= '0;
                            b <= b >> 1;
                            if (n == N_LAST) begin
                                state <= (PAR_EN != 0) ? PARITY : STOP;
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s == S_LAST) begin
                            s     <= '0;
                            state <= STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == STOP_LAST) begin
                            state <= IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx               = tx_reg;
    assign bus.tx_busy      = (state != IDLE);
    assign bus.tx_done_tick = (state == STOP) && s_tick && (s == STOP_LAST);
endmodule

// File: tb/tb_uart_transmitter.sv
// Randomized scoreboard bench: five transmitter configurations share clk/reset/s_tick; each
// frame is predicted per s_tick from din and the frame format, then checked on tx and done.
module tb_uart_transmitter;
    localparam int N      = 5;
    localparam int FIFO_D = 64;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         s_tick = 1'b0;
    logic [N-1:0] start  = '0;
    logic [N-1:0] tx_v;
    logic [N-1:0] busy;
    logic [N-1:0] done;
    logic [7:0]   din_v [N];

    int total = 0;
    int bad   = 0;
    int tick_mode = 0;

    logic [7:0] exp_din   [N][FIFO_D];
    bit         exp_abort [N][FIFO_D];
    int         wr_ptr [N];
    int         rd_ptr [N];
    bit         mon_active [N];

    function automatic int cfg_dbit(input int i);
        case (i)
            3:       return 7;
            4:       return 5;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_sb(input int i);
        case (i)
            3:       return 32;
            4:       return 24;
            default: return 16;
        endcase
    endfunction

    function automatic int cfg_par(input int i);
        return (i == 1 || i == 2 || i == 4) ? 1 : 0;
    endfunction

    function automatic int cfg_odd(input int i);
        return (i == 2 || i == 4) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < N; g++) begin : gen_dut
        uart_transmitter_if bus ();
        assign bus.tx_start = start[g];
        assign bus.din      = din_v[g];
        assign busy[g]      = bus.tx_busy;
        assign done[g]      = bus.tx_done_tick;

        uart_transmitter #(
            .DBIT    (cfg_dbit(g)),
            .SB_TICK (cfg_sb(g)),
            .PAR_EN  (cfg_par(g)),
            .PAR_ODD (cfg_odd(g))
        ) dut (
            .clk    (clk),
            .reset  (reset),
            .s_tick (s_tick),
            .bus    (bus),
            .tx     (tx_v[g])
        );
    end

    always #5 clk = ~clk;

    task automatic check(input string name, input int d, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d, want %0d", name, d, act, req);
        end
    endtask

    // Line level during s_tick number t (1-based) of a frame.
    function automatic logic ref_level(input int d, input logic [7:0] v, input int t);
        int seg;
        int ones;
        seg  = (t - 1) / 16;
        ones = 0;
        if (seg == 0) return 1'b0;
        if (seg <= cfg_dbit(d)) return v[seg-1];
        if (cfg_par(d) == 1 && seg == cfg_dbit(d) + 1) begin
            for (int i = 0; i < cfg_dbit(d); i++) ones += int'(v[i]);
            return 1'((ones + cfg_odd(d)) % 2);
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] directed(input int i);
        case (i)
            0:       return 8'h55;
            1:       return 8'h07;
            2:       return 8'h03;
            3:       return 8'hFF;
            default: return 8'hAA;
        endcase
    endfunction

    task automatic push(input int d, input logic [7:0] v, input bit ab);
        exp_din[d][wr_ptr[d] % FIFO_D]   = v;
        exp_abort[d][wr_ptr[d] % FIFO_D] = ab;
        wr_ptr[d]++;
    endtask

    // A tick seen at a negedge is consumed at the next posedge; tx shows the resulting
    // state one clock later, so each tick's sample is taken two negedges after it.
    task automatic monitor(input int d);
        int         len;
        int         tick_cnt;
        int         first_bad;
        int         slot;
        bit         in_frame;
        bit         done_seen;
        bit         busy_prev;
        bit         pend0;
        bit         pend1;
        bit         matured;
        logic       samples [$];
        logic [7:0] cur_din;
        bit         cur_abort;
        len = 16 * (1 + cfg_dbit(d) + cfg_par(d)) + cfg_sb(d);
        tick_cnt = 0; in_frame = 0; done_seen = 0; busy_prev = 0;
        pend0 = 0; pend1 = 0; cur_din = '0; cur_abort = 0;
        forever begin
            @(negedge clk);
            matured = pend1;
            pend1   = pend0;
            pend0   = 0;
            if (in_frame && matured) samples.push_back(tx_v[d]);
            if (in_frame && done_seen && samples.size() == tick_cnt) begin
                first_bad = -1;
                for (int k = 1; k <= tick_cnt; k++) begin
                    logic e;
                    e = (k < len) ? ref_level(d, cur_din, k + 1) : 1'b1;
                    if (samples[k-1] !== e && first_bad < 0) first_bad = k;
                end
                check("frame_bits_first_bad_tick", d, first_bad, -1);
                check("frame_completed_flag", d, 0, int'(cur_abort));
                in_frame = 0;
            end
            if (in_frame && !done_seen && busy[d] !== 1'b1) begin
                check("frame_abort_expected", d, 1, int'(cur_abort));
                check("abort_tx_level", d, int'(tx_v[d]), 1);
                in_frame = 0;
            end
            if (!busy_prev && busy[d] === 1'b1) begin
                check("frame_overlap", d, int'(in_frame), 0);
                check("frame_pending_in_queue", d, int'(wr_ptr[d] > rd_ptr[d]), 1);
                if (wr_ptr[d] > rd_ptr[d]) begin
                    slot      = rd_ptr[d] % FIFO_D;
                    cur_din   = exp_din[d][slot];
                    cur_abort = exp_abort[d][slot];
                    rd_ptr[d]++;
                end
                in_frame = 1; done_seen = 0; tick_cnt = 0;
                samples.delete();
                pend0 = 0; pend1 = 0;
            end
            if (in_frame && !done_seen && busy[d] === 1'b1 && s_tick) begin
                tick_cnt++;
                pend0 = 1;
            end
            if (done[d] === 1'b1) begin
                check("done_at_tick", d, (in_frame && !done_seen && s_tick) ? tick_cnt : -1, len);
                done_seen = 1;
            end
            busy_prev     = (busy[d] === 1'b1);
            mon_active[d] = in_frame;
        end
    endtask

    task automatic drive(input int d, input int nframes, input bit use_dir);
        int         sent;
        int         gap;
        int         guard;
        logic [7:0] v;
        sent = 0; gap = 0; guard = 0;
        while (sent < nframes && guard < 30000) begin
            @(negedge clk);
            guard++;
            start[d] = 1'b0;
            din_v[d] = 8'($urandom);
            if (busy[d] === 1'b0) begin
                if (gap == 0) begin
                    v = (use_dir && sent < 5) ? directed(sent) : 8'($urandom);
                    din_v[d] = v;
                    start[d] = 1'b1;
                    push(d, v, 1'b0);
                    sent++;
                    gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 12));
                end else begin
                    gap--;
                end
            end else if (done[d] === 1'b1 || $urandom_range(0, 31) == 0) begin
                start[d] = 1'b1;
            end
        end
        @(negedge clk);
        start[d] = 1'b0;
        check("driver_frames_sent", d, sent, nframes);
    endtask

    task automatic run_drivers(input int nf, input bit use_dir);
        for (int d = 0; d < N; d++) begin
            automatic int dd = d;
            fork
                drive(dd, nf, use_dir);
            join_none
        end
        wait fork;
    endtask

    task automatic wait_quiet();
        int g;
        bit act;
        g = 0;
        do begin
            @(negedge clk);
            g++;
            act = 0;
            for (int d = 0; d < N; d++) if (mon_active[d]) act = 1;
        end while ((busy !== '0 || act) && g < 5000);
        check("settle_within_budget", 0, int'(g < 5000), 1);
    endtask

    initial begin
        int gap;
        gap = 0;
        forever begin
            @(negedge clk);
            if (gap == 0) begin
                s_tick = 1'b1;
                gap = (tick_mode == 0) ? 3 : int'($urandom_range(0, 8));
            end else begin
                s_tick = 1'b0;
                gap--;
            end
        end
    end

    initial begin
        for (int d = 0; d < N; d++) begin
            automatic int dd = d;
            fork
                monitor(dd);
            join_none
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit [N-1:0] viol;
        int         cnt;
        for (int d = 0; d < N; d++) begin
            din_v[d] = '0; wr_ptr[d] = 0; rd_ptr[d] = 0; mon_active[d] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < N; d++) check("reset_state_tx_busy_done", d, int'({tx_v[d], busy[d], done[d]}), 4);
        reset = 1'b0;

        viol = '0;
        repeat (1000) begin
            @(negedge clk);
            for (int d = 0; d < N; d++) if ({tx_v[d], busy[d], done[d]} !== 3'b100) viol[d] = 1'b1;
        end
        for (int d = 0; d < N; d++) check("idle_quiet_1000", d, int'(viol[d]), 0);

        tick_mode = 0;
        run_drivers(5, 1'b1);
        wait_quiet();
        tick_mode = 1;
        run_drivers(20, 1'b0);
        wait_quiet();

        // Abandon a frame in data bit 3 with a synchronous reset.
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            din_v[d] = 8'hC3 ^ 8'(d);
            start[d] = 1'b1;
            push(d, din_v[d], 1'b1);
        end
        cnt = 0;
        @(negedge clk);
        start = '0;
        if (s_tick) cnt++;
        while (cnt < 72) begin
            @(negedge clk);
            if (s_tick) cnt++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < N; d++) check("after_reset_tx_busy_done", d, int'({tx_v[d], busy[d], done[d]}), 4);

        run_drivers(2, 1'b0);
        wait_quiet();
        for (int d = 0; d < N; d++) check("all_frames_observed", d, rd_ptr[d], wr_ptr[d]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- UART serializer; the transmit end of the same link whose receive side samples with a 16x oversampling tick.
- Shares the same baud-rate tick generator (s_tick, 16 ticks per bit) with the receive side.
- Accepts a parallel byte on a one-cycle start strobe and emits start bit, DBIT data bits (LSB first), optional parity bit and stop bit(s) on tx.
- Sits between the core datapath (e.g. CORDIC result formatter) and the board TX pin.

Parameters:
- DBIT, 8, number of data bits per frame; legal 5..8; din[DBIT-1:0] is sent, upper bits ignored.
- SB_TICK, 16, s_ticks spent in stop state: 16 = 1 stop bit, 24 = 1.5, 32 = 2; legal 16..32.
- PAR_EN, 0, 1 inserts a parity bit after the data bits.
- PAR_ODD, 0, parity sense when PAR_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_start  input  1  one-cycle request to send din; honoured only in idle.
- s_tick  input  1  one-clock enable pulse at 16x baud rate.
- din  input  8  byte to transmit; sampled on the accepted tx_start cycle only.
- tx_busy  output  1  high whenever state is not idle.
- tx_done_tick  output  1  one-cycle pulse at the end of the stop interval.
- tx  output  1  serial line, registered, idle high.

Behaviour:
- Registers: state, s (5-bit tick counter), n (3-bit bit counter), b (8-bit shift), p (parity bit), tx_reg.
- Reset (clk edge with reset=1):
  - state=idle, s=0, n=0, b=0, p=0, tx_reg=1.
  - Outputs: tx=1, tx_busy=0, tx_done_tick=0.
  - Applies mid-frame: the line returns high on the next edge and the frame is abandoned, no done pulse.
- States and transitions:
  - idle: tx_next=1. If tx_start=1:
    - b<=din, s<=0, p<=XOR(din[DBIT-1:0])^PAR_ODD, go to start.
    - s_tick is not required for this transition.
  - start: tx_next=0. On each s_tick:
    - If s==15: s<=0, n<=0, go to data.
    - Otherwise s<=s+1.
  - data: tx_next=b[0]. On s_tick with s==15:
    - s<=0, b<=b>>1.
    - If n==DBIT-1, go to parity when PAR_EN=1, otherwise to stop.
    - Otherwise n<=n+1.
    - On any other s_tick: s<=s+1.
  - parity: tx_next=p. On s_tick:
    - If s==15: s<=0, go to stop.
    - Otherwise s<=s+1.
  - stop: tx_next=1. On s_tick:
    - If s==SB_TICK-1: tx_done_tick=1 (combinational, that cycle only), go to idle.
    - Otherwise s<=s+1.
- Output timing:
  - tx=tx_reg, where tx_reg<=tx_next every clock, so tx lags state by exactly one clk.
  - Each start, data and parity bit lasts exactly 16 s_ticks; stop lasts SB_TICK s_ticks.
  - tx_busy is combinational from state (state!=idle).
- Boundary conditions:
  - tx_start while busy, including the tx_done_tick cycle, is ignored; din is not resampled.
  - A tx_start in the first idle cycle after done starts the next frame, with no extra idle time beyond one clk.
  - Clocks without s_tick hold s, n, b and state unchanged, except for idle->start.
  - s_tick coincident with an accepted tx_start does not count toward the start bit; counting begins in the start state.
  - din changes after acceptance do not affect the frame in flight.
  - Counter widths: s is 5 bits so SB_TICK=32 reaches 31 without wrap; n compares to DBIT-1 and never exceeds 7.
  - Frame length in s_ticks: 16*(1+DBIT+PAR_EN)+SB_TICK.

Test Plan:
- Reset/idle: hold reset 3 clks, then release with no tx_start -> tx=1, tx_busy=0, tx_done_tick=0 for 1000 clks.
- Basic frame: defaults, s_tick every 4 clks, din=0x55 pulse -> tx low for 64 clks, then bits 1,0,1,0,1,0,1,0 at 64 clks each, high 64 clks; exactly one tx_done_tick; tx_busy high 640 clks.
- Parity: PAR_EN=1/PAR_ODD=0, din=0x07 -> parity bit 1; PAR_ODD=1 -> 0; din=0x03 with even parity -> 0; frame is 11 bit times.
- Busy rejection and back-to-back:
  - tx_start with din=0xAA mid-frame of 0x55 -> ignored, only 0x55 sent.
  - tx_start with 0xAA the cycle after done -> second frame starts, start bit on the next edge.
- Reset mid-data: assert reset during data bit 3 -> tx=1 and tx_busy=0 after the edge; no done pulse; next tx_start sends a full clean frame.
- Stop and width variants:
  - DBIT=7, SB_TICK=32, din=0xFF -> 7 ones after start, stop high 32 ticks, din[7] never sent.
  - Irregular s_tick gaps (1–9 clks) -> bit lengths still exactly 16 ticks each.
